// File: rtl/decode_pkg.sv
// Shared opcode constants, class codes, FSM encoding and decoded-field layout
// for the instruction decode stage.
package decode_pkg;

  localparam logic [5:0] OP_ALU_R     = 6'h00;
  localparam logic [5:0] OP_ALU_I_LO  = 6'h01;
  localparam logic [5:0] OP_ALU_I_HI  = 6'h0F;
  localparam logic [5:0] OP_LOAD      = 6'h10;
  localparam logic [5:0] OP_STORE     = 6'h11;
  localparam logic [5:0] OP_BRANCH_LO = 6'h12;
  localparam logic [5:0] OP_BRANCH_HI = 6'h13;
  localparam logic [5:0] OP_JUMP      = 6'h14;
  localparam logic [5:0] OP_NOP       = 6'h3F;

  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_ALU_R   = 3'd1,
    CLS_ALU_I   = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4,
    CLS_BRANCH  = 3'd5,
    CLS_JUMP    = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

  typedef struct packed {
    logic [5:0]   opcode;
    logic [4:0]   rd;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [5:0]   funct;
    logic [31:0]  imm;
    instr_class_e cls;
  } dec_fields_t;

  function automatic instr_class_e classify(input logic [5:0] op);
    instr_class_e c;
    if (op == OP_ALU_R)                                 c = CLS_ALU_R;
    else if (op >= OP_ALU_I_LO && op <= OP_ALU_I_HI)    c = CLS_ALU_I;
    else if (op == OP_LOAD)                             c = CLS_LOAD;
    else if (op == OP_STORE)                            c = CLS_STORE;
    else if (op >= OP_BRANCH_LO && op <= OP_BRANCH_HI)  c = CLS_BRANCH;
    else if (op == OP_JUMP)                             c = CLS_JUMP;
    else if (op == OP_NOP)                              c = CLS_NOP;
    else                                                c = CLS_ILLEGAL;
    return c;
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational split of a 32-bit instruction word into fields,
// class code and class-dependent immediate.
module instr_field_decode
  import decode_pkg::*;
(
  input  logic [31:0] word_i,
  output dec_fields_t fields_o
);

  instr_class_e cls;

  assign cls = classify(word_i[31:26]);

  always_comb begin
    fields_o        = '0;
    fields_o.opcode = word_i[31:26];
    fields_o.rd     = word_i[25:21];
    fields_o.rs     = word_i[20:16];
    fields_o.rt     = word_i[15:11];
    fields_o.funct  = word_i[5:0];
    fields_o.cls    = cls;
    case (cls)
      CLS_JUMP:                      fields_o.imm = {4'b0000, word_i[25:0], 2'b00};
      CLS_ALU_R, CLS_NOP, CLS_ILLEGAL: fields_o.imm = 32'd0;
      default:                       fields_o.imm = {{16{word_i[15]}}, word_i[15:0]};
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// One-deep decode stage: DOR/ack capture, decode, DOR/ack present; >=3 cycles per word.
// Define ILLEGAL_TRAP_EN to make an ILLEGAL word set a sticky flag that halts capture.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_DOR,
  input  logic [31:0]            in_data,
  output logic                   in_ack,
  output logic                   out_DOR,
  input  logic                   out_ack,
  output logic [5:0]             out_opcode,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs,
  output logic [4:0]             out_rt,
  output logic [5:0]             out_funct,
  output logic [31:0]            out_imm,
  output logic [2:0]             out_class,
  output logic [COUNT_WIDTH-1:0] decoded_count,
  output logic                   illegal_flag
);

  state_e                 state_q, state_d;
  logic                   armed_q, armed_d;
  logic                   in_ack_q, in_ack_d;
  logic                   out_dor_q, out_dor_d;
  logic [31:0]            word_q;
  dec_fields_t            fields_q, fields_dec;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   capture, load_fields, handoff;
  logic                   trap_q;

  instr_field_decode u_field_decode (
    .word_i   (word_q),
    .fields_o (fields_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (capture) state_d = ST_ACK;
      ST_ACK:     state_d = ST_PRESENT;
      ST_PRESENT: if (out_ack) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Re-arming on any low sample of in_DOR stops a word still held high after its ack being taken twice.
  always_comb begin
    capture     = (state_q == ST_IDLE) && armed_q && in_DOR && !trap_q;
    load_fields = (state_q == ST_ACK);
    handoff     = (state_q == ST_PRESENT) && out_ack;
    in_ack_d    = capture;
    out_dor_d   = out_dor_q;
    if (load_fields)  out_dor_d = 1'b1;
    else if (handoff) out_dor_d = 1'b0;
    armed_d = armed_q;
    if (capture)      armed_d = 1'b0;
    else if (!in_DOR) armed_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q   <= 1'b1;
      in_ack_q  <= 1'b0;
      out_dor_q <= 1'b0;
      word_q    <= '0;
      fields_q  <= '0;
      count_q   <= '0;
    end else begin
      armed_q   <= armed_d;
      in_ack_q  <= in_ack_d;
      out_dor_q <= out_dor_d;
      if (capture)     word_q   <= in_data;
      if (load_fields) fields_q <= fields_dec;
      if (handoff)     count_q  <= count_q + COUNT_WIDTH'(1);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         trap_q <= 1'b0;
    else if (handoff && fields_q.cls == CLS_ILLEGAL)   trap_q <= 1'b1;
  end
`else
  assign trap_q = 1'b0;
`endif

  assign in_ack        = in_ack_q;
  assign out_DOR       = out_dor_q;
  assign out_opcode    = fields_q.opcode;
  assign out_rd        = fields_q.rd;
  assign out_rs        = fields_q.rs;
  assign out_rt        = fields_q.rt;
  assign out_funct     = fields_q.funct;
  assign out_imm       = fields_q.imm;
  assign out_class     = fields_q.cls;
  assign decoded_count = count_q;
  assign illegal_flag  = trap_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: expected decodes queued on offer, compared on presentation.
module tb_instr_decode_stage;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_DOR;
  logic [31:0]   in_data;
  logic          in_ack;
  logic          out_DOR;
  logic          out_ack;
  logic [5:0]    out_opcode;
  logic [4:0]    out_rd, out_rs, out_rt;
  logic [5:0]    out_funct;
  logic [31:0]   out_imm;
  logic [2:0]    out_class;
  logic [CW-1:0] decoded_count;
  logic          illegal_flag;

  instr_decode_stage #(.COUNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_DOR        (in_DOR),
    .in_data       (in_data),
    .in_ack        (in_ack),
    .out_DOR       (out_DOR),
    .out_ack       (out_ack),
    .out_opcode    (out_opcode),
    .out_rd        (out_rd),
    .out_rs        (out_rs),
    .out_rt        (out_rt),
    .out_funct     (out_funct),
    .out_imm       (out_imm),
    .out_class     (out_class),
    .decoded_count (decoded_count),
    .illegal_flag  (illegal_flag)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_cnt  = 0;
  int          exp_cnt  = 0;
  int          hold_ctr = 0;
  int          bp_delay = 0;
  bit          presenting = 0;
  logic [63:0] snap;
  logic [63:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode, packed as {opcode, rd, rs, rt, funct, imm, class}.
  function automatic logic [63:0] model(input logic [31:0] w);
    logic [5:0]  op;
    logic [2:0]  c;
    logic [31:0] imm;
    op = w[31:26];
    if (op == 6'h00)                      c = 3'd1;
    else if (op <= 6'h0F)                 c = 3'd2;
    else if (op == 6'h10)                 c = 3'd3;
    else if (op == 6'h11)                 c = 3'd4;
    else if (op == 6'h12 || op == 6'h13)  c = 3'd5;
    else if (op == 6'h14)                 c = 3'd6;
    else if (op == 6'h3F)                 c = 3'd0;
    else                                  c = 3'd7;
    if (c == 3'd6)                              imm = {4'b0, w[25:0], 2'b00};
    else if (c == 3'd0 || c == 3'd1 || c == 3'd7) imm = 32'd0;
    else                                        imm = {{16{w[15]}}, w[15:0]};
    return {2'b00, op, w[25:21], w[20:16], w[15:11], w[5:0], imm, c};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {2'b00, out_opcode, out_rd, out_rs, out_rt, out_funct, out_imm, out_class};
  endfunction

  always @(posedge clk) begin
    #2;
    if (in_ack === 1'b1) ack_cnt++;
  end

  // One cycle: sample at negedge, then act as the downstream consumer.
  task automatic cyc();
    @(negedge clk);
    if (out_DOR === 1'b1) begin
      if (!presenting) begin
        presenting = 1;
        snap       = dut_vec();
        hold_ctr   = bp_delay;
        bp_delay   = 0;
      end else begin
        chk("stable", dut_vec(), snap);
      end
      if (hold_ctr > 0) begin
        hold_ctr--;
        out_ack = 1'b0;
      end else if (out_ack !== 1'b1) begin
        if (sb.size() == 0) chk("unexpected_output", dut_vec(), 64'h0);
        else                chk("fields", dut_vec(), sb.pop_front());
        out_ack = 1'b1;
        exp_cnt++;
      end
    end else begin
      out_ack    = 1'b0;
      presenting = 0;
    end
  endtask

  task automatic offer(input logic [31:0] w);
    in_data = w;
    in_DOR  = 1'b1;
    sb.push_back(model(w));
  endtask

  task automatic wait_ack();
    bit seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (in_ack === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (sb.size() == 0 && out_DOR === 1'b0 && out_ack === 1'b0) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input logic [31:0] w);
    offer(w);
    wait_ack();
    in_DOR = 1'b0;
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0;
    logic [31:0] tbl [4];
    tbl[0] = 32'h4C00FFFF;
    tbl[1] = 32'h00221820;
    tbl[2] = 32'h3C1F7FFF;
    tbl[3] = 32'hFC0012AB;

    reset = 1'b1; in_DOR = 1'b0; in_data = '0; out_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_dor", out_DOR, 0);
    chk("rst_in_ack", in_ack, 0);
    chk("rst_count", decoded_count, 0);
    chk("rst_flag", illegal_flag, 0);
    chk("rst_fields", dut_vec(), 64'h0);
    reset = 1'b0;
    cyc();

    // Single LOAD with latency checks
    a0 = ack_cnt;
    offer(32'h4022FFFC);
    wait_ack();
    in_DOR = 1'b0;
    cyc();
    chk("load_lat_dor", out_DOR, 1);
    chk("load_ack_low", in_ack, 0);
    chk("load_class", out_class, 3);
    chk("load_rd", out_rd, 1);
    chk("load_rs", out_rs, 2);
    chk("load_imm", out_imm, 32'hFFFFFFFC);
    drain();
    chk("load_count", decoded_count, 1);
    chk("load_one_ack", ack_cnt - a0, 1);

    // JUMP immediate
    offer(32'h50000010);
    wait_ack();
    in_DOR = 1'b0;
    cyc();
    chk("jump_class", out_class, 6);
    chk("jump_imm", out_imm, 32'h00000040);
    drain();

    foreach (tbl[i]) send(tbl[i]);
    chk("table_count", decoded_count, CW'(exp_cnt));

    // Re-arm: one word held high for 10 cycles
    a0 = ack_cnt;
    offer(32'h14648001);
    repeat (10) cyc();
    chk("rearm_one_ack", ack_cnt - a0, 1);
    chk("rearm_sb_empty", sb.size(), 0);
    in_DOR = 1'b0;
    cyc();
    send(32'h08A5FFFE);
    chk("rearm_second_ack", ack_cnt - a0, 2);
    chk("rearm_count", decoded_count, CW'(exp_cnt));

    // Backpressure: out_ack held off 5 cycles while next word is offered
    bp_delay = 5;
    offer(32'h44001234);
    wait_ack();
    in_DOR = 1'b0;
    cyc();
    offer(32'h00221820);
    a0 = exp_cnt;
    begin
      int k0;
      k0 = ack_cnt;
      for (int i = 0; i < 20; i++) begin
        cyc();
        if (out_DOR === 1'b0) break;
      end
      chk("bp_no_ack_while_present", ack_cnt - k0, 0);
      chk("bp_count_once", decoded_count, CW'(a0 + 1));
    end
    wait_ack();
    in_DOR = 1'b0;
    drain();
    chk("bp_count_final", decoded_count, CW'(exp_cnt));

    // Reset mid-PRESENT
    bp_delay = 50;
    offer(32'h4800000C);
    wait_ack();
    in_DOR = 1'b0;
    cyc();
    cyc();
    chk("pre_rst_dor", out_DOR, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_dor", out_DOR, 0);
    chk("arst_in_ack", in_ack, 0);
    chk("arst_count", decoded_count, 0);
    sb.delete();
    presenting = 0; hold_ctr = 0; bp_delay = 0; out_ack = 1'b0; exp_cnt = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send(32'h4022FFFC);
    chk("post_rst_count", decoded_count, 1);

    // NOP then ILLEGAL
    send(32'hFC000000);
    send(32'h84000000);
    cyc();
`ifdef ILLEGAL_TRAP_EN
    chk("trap_flag", illegal_flag, 1);
    a0 = ack_cnt;
    in_data = 32'h4022FFFC;
    in_DOR  = 1'b1;
    repeat (10) cyc();
    in_DOR = 1'b0;
    chk("trap_no_ack", ack_cnt - a0, 0);
    chk("trap_no_dor", out_DOR, 0);
    chk("trap_count", decoded_count, 3);
`else
    chk("no_trap_flag", illegal_flag, 0);
    a0 = ack_cnt;
    send(32'h4022FFFC);
    chk("no_trap_flow_ack", ack_cnt - a0, 1);
    chk("no_trap_count", decoded_count, 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Downstream neighbour of the instruction pipeline. Consumes the 32-bit words the pipeline emits through its DOR/data_out/ack handshake.
- Splits each word into fields and classifies it. Presents the result to the execute stage through the same DOR/ack handshake style.
- Buffers one instruction at a time. Keeps a running count of decoded instructions.

Parameters:
- COUNT_WIDTH, 16, width of decoded_count; wraps modulo 2^COUNT_WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_DOR  in  1  upstream pipeline has a word ready
- in_data  in  32  upstream word
- in_ack  out  1  registered one-cycle pulse acknowledging capture
- out_DOR  out  1  decoded instruction valid
- out_ack  in  1  downstream accepted decoded instruction
- out_opcode  out  6  word[31:26]
- out_rd  out  5  word[25:21]
- out_rs  out  5  word[20:16]
- out_rt  out  5  word[15:11]
- out_funct  out  6  word[5:0]
- out_imm  out  32  immediate, per class rules below
- out_class  out  3  instruction class code
- decoded_count  out  COUNT_WIDTH  instructions handed downstream
- illegal_flag  out  1  sticky trap flag (optional feature)

Behaviour:
- Reset (async, active-high):
  - State IDLE; armed=1.
  - in_ack=0, out_DOR=0, all out_* fields 0, decoded_count=0, illegal_flag=0.
- States: IDLE, ACK, PRESENT.
- IDLE:
  - If armed and in_DOR=1: latch in_data into word_reg, set in_ack<=1, armed<=0, go to ACK.
  - If in_DOR=0: armed<=1.
- ACK:
  - in_ack<=0.
  - Register decoded fields from word_reg and set out_DOR<=1; go to PRESENT.
- PRESENT:
  - Hold out_DOR and all fields stable until out_ack=1 is sampled.
  - On out_ack=1: out_DOR<=0, decoded_count<=decoded_count+1, go to IDLE.
  - out_ack outside PRESENT is ignored.
  - While in ACK or PRESENT, if in_DOR=0 is sampled, set armed<=1.
- Re-arm rule: a new word is accepted only after in_DOR has been sampled low at least once since the previous capture. This guarantees no double capture if upstream drops DOR one cycle after ack.
- Latency and throughput:
  - in_DOR sampled at edge N → in_ack high in cycle N..N+1 → out_DOR high from edge N+1.
  - Minimum of 3 cycles per instruction when out_ack returns immediately.
- Class encoding: NOP=0, ALU_R=1, ALU_I=2, LOAD=3, STORE=4, BRANCH=5, JUMP=6, ILLEGAL=7.
- Opcode map:
  - 0x00 → ALU_R
  - 0x01–0x0F → ALU_I
  - 0x10 → LOAD
  - 0x11 → STORE
  - 0x12–0x13 → BRANCH
  - 0x14 → JUMP
  - 0x3F → NOP
  - all others → ILLEGAL
- out_imm rules:
  - JUMP: zero-extended {word[25:0],2'b00}.
  - ALU_R, NOP, ILLEGAL: 0.
  - All other classes: sign-extended word[15:0].
- decoded_count wraps from all-ones to 0 without a flag.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- When defined:
  - An ILLEGAL-class word still goes through ACK and PRESENT and is handed downstream once.
  - On its out_ack, illegal_flag<=1 (sticky).
  - While illegal_flag=1 the block stays in IDLE and never captures again; in_ack stays 0. Only reset clears it.
- When undefined:
  - illegal_flag is tied 0.
  - ILLEGAL words flow like any other class.

Decomposition:
- Package decode_pkg holds:
  - opcode constants
  - class codes (3-bit)
  - state encoding for IDLE/ACK/PRESENT
- One combinational sub-module, instr_field_decode: word in → opcode/rd/rs/rt/funct/imm/class out.
- The stage instantiates instr_field_decode and owns all registers.

Test Plan:
- Reset mid-PRESENT:
  - Stimulus: assert reset while out_DOR=1.
  - Required response: out_DOR, in_ack and decoded_count go to 0 immediately (asynchronously). The next word after release is captured normally.
- Single LOAD:
  - Stimulus: in_data=0x4022FFFC (opcode 0x10, rd=1, rs=2, imm=0xFFFC), in_DOR held until in_ack.
  - Required response: one in_ack pulse; out_class=3, out_rd=1, out_rs=2, out_imm=0xFFFFFFFC; decoded_count=1 after out_ack.
- JUMP immediate:
  - Stimulus: in_data=0x50000010.
  - Required response: out_class=6, out_imm=0x00000040.
- Re-arm:
  - Stimulus: hold in_DOR=1 for 10 cycles with one word.
  - Required response: exactly one capture and one in_ack pulse. A second word is captured only after in_DOR has gone low then high again.
- Backpressure:
  - Stimulus: delay out_ack by 5 cycles while upstream offers the next word.
  - Required response: fields stay stable; no in_ack is issued until PRESENT exits; decoded_count increments once.
- ILLEGAL_TRAP_EN:
  - Stimulus: in_data=0xFC000000 (opcode 0x3F, NOP) → class 0. Then 0x84000000 (opcode 0x21) → class 7.
  - Required response: with the macro defined, illegal_flag=1 after out_ack and further in_DOR is never acked. With the macro undefined, flow continues.
